// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns single-cycle pipeline load/store requests
// into a request/acknowledge bus transaction with timeout and illegal-access abort.
module dmem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memrd,
  input  logic        memwr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access_req;
  logic        illegal;

  assign access_req = (memrd | memwr) & ~flush;
  assign illegal    = (memrd & memwr) | (addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    stall   = 1'b0;
    rvalid  = 1'b0;
    err     = 1'b0;
    bus_req = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access_req) begin
          stall = 1'b1;
          if (illegal) begin
            state_d = ERR;
          end else begin
            state_d = REQ;
            addr_d  = addr;
            wdata_d = wdata;
            we_d    = memwr;
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        // An ack on the final allowed cycle still completes the access.
        if (bus_ack) begin
          state_d = DONE;
          if (!we_q) rdata_d = bus_rdata;
        end else if (cnt_q == TmoLast) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        rvalid  = ~we_q;
        state_d = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_we    = bus_req & we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl with a short timeout (TIMEOUT=4).
module tb_dmem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        memrd;
  logic        memwr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        flush;
  logic        stall;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks = 0;
  int errors = 0;

  dmem_ctrl #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .memrd    (memrd),
    .memwr    (memwr),
    .addr     (addr),
    .wdata    (wdata),
    .flush    (flush),
    .stall    (stall),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .err      (err),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_ack  (bus_ack),
    .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then let inputs change well after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                               input logic [31:0] d, input logic fl,
                               input logic ack, input logic [31:0] rdat);
    memrd     = rd;
    memwr     = wr;
    addr      = a;
    wdata     = d;
    flush     = fl;
    bus_ack   = ack;
    bus_rdata = rdat;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    #3;
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_bus_req", bus_req, 0);
    checkOutput("rst_bus_we", bus_we, 0);
    checkOutput("rst_bus_addr", bus_addr, 32'h0);
    checkOutput("rst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_rdata", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load hit: ack in the first REQ cycle
    applyStimulus(1, 0, 32'h0000_1000, 32'h0, 0, 0, 32'h0);
    checkOutput("ld_accept_stall", stall, 1);
    checkOutput("ld_accept_bus_req", bus_req, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("ld_req_stall", stall, 1);
    checkOutput("ld_req_bus_req", bus_req, 1);
    checkOutput("ld_req_bus_we", bus_we, 0);
    checkOutput("ld_req_bus_addr", bus_addr, 32'h0000_1000);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("ld_done_stall", stall, 0);
    checkOutput("ld_done_rvalid", rvalid, 1);
    checkOutput("ld_done_rdata", rdata, 32'hDEAD_BEEF);
    checkOutput("ld_done_bus_req", bus_req, 0);
    tick();
    checkOutput("ld_idle_rvalid", rvalid, 0);
    checkOutput("ld_idle_rdata_hold", rdata, 32'hDEAD_BEEF);

    // Store with wait states: ack in the third REQ cycle
    applyStimulus(0, 1, 32'h0000_2FFC, 32'h1234_5678, 0, 0, 32'h0);
    checkOutput("st_accept_stall", stall, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, (i == 2), 32'h5555_5555);
      checkOutput("st_req_bus_req", bus_req, 1);
      checkOutput("st_req_bus_we", bus_we, 1);
      checkOutput("st_req_bus_addr", bus_addr, 32'h0000_2FFC);
      checkOutput("st_req_bus_wdata", bus_wdata, 32'h1234_5678);
      checkOutput("st_req_stall", stall, 1);
    end
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("st_done_rvalid", rvalid, 0);
    checkOutput("st_done_err", err, 0);
    checkOutput("st_done_stall", stall, 0);
    checkOutput("st_done_bus_we", bus_we, 0);
    checkOutput("st_done_rdata_hold", rdata, 32'hDEAD_BEEF);
    tick();

    // Timeout: no ack, four REQ cycles then a single err pulse
    applyStimulus(1, 0, 32'h0000_0040, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
      checkOutput("tmo_req_bus_req", bus_req, 1);
      checkOutput("tmo_req_err", err, 0);
    end
    tick();
    checkOutput("tmo_err", err, 1);
    checkOutput("tmo_err_stall", stall, 0);
    checkOutput("tmo_err_bus_req", bus_req, 0);
    checkOutput("tmo_err_rvalid", rvalid, 0);
    checkOutput("tmo_rdata_hold", rdata, 32'hDEAD_BEEF);
    tick();
    checkOutput("tmo_err_clear", err, 0);

    // Ack on the final timeout cycle wins over the abort
    applyStimulus(1, 0, 32'h0000_0080, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      applyStimulus(0, 0, 32'h0, 32'h0, 0, (i == 3), 32'h0BAD_F00D);
      checkOutput("lastack_bus_req", bus_req, 1);
    end
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("lastack_err", err, 0);
    checkOutput("lastack_rvalid", rvalid, 1);
    checkOutput("lastack_rdata", rdata, 32'h0BAD_F00D);
    tick();

    // Illegal: both read and write
    applyStimulus(1, 1, 32'h0000_0100, 32'h0, 0, 0, 32'h0);
    checkOutput("ill_both_stall", stall, 1);
    checkOutput("ill_both_bus_req", bus_req, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("ill_both_err", err, 1);
    checkOutput("ill_both_bus_req_err", bus_req, 0);
    tick();
    checkOutput("ill_both_err_clear", err, 0);

    // Illegal: misaligned address
    applyStimulus(1, 0, 32'h0000_1002, 32'h0, 0, 0, 32'h0);
    checkOutput("ill_mis_bus_req", bus_req, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("ill_mis_err", err, 1);
    checkOutput("ill_mis_bus_req_err", bus_req, 0);
    tick();

    // Flush in IDLE suppresses acceptance
    applyStimulus(0, 1, 32'h0000_3000, 32'hAAAA_AAAA, 1, 0, 32'h0);
    checkOutput("flush_stall", stall, 0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("flush_bus_req", bus_req, 0);
    checkOutput("flush_err", err, 0);
    checkOutput("flush_bus_addr", bus_addr, 32'h0000_0080);

    // Stray ack in IDLE is ignored
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 32'h7777_7777);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("stray_rvalid", rvalid, 0);
    checkOutput("stray_bus_req", bus_req, 0);
    checkOutput("stray_rdata", rdata, 32'h0BAD_F00D);
    tick();
    checkOutput("stray_after_rvalid", rvalid, 0);

    // Flush during REQ does not abort
    applyStimulus(1, 0, 32'h0000_0200, 32'h0, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 0, 32'h0);
    checkOutput("flreq_bus_req", bus_req, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 1, 1, 32'hCAFE_F00D);
    checkOutput("flreq_bus_req2", bus_req, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("flreq_rvalid", rvalid, 1);
    checkOutput("flreq_rdata", rdata, 32'hCAFE_F00D);
    tick();

    // Reset mid-access drops bus_req asynchronously
    applyStimulus(0, 1, 32'h0000_0300, 32'h1111_2222, 0, 0, 32'h0);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("mrst_pre_bus_req", bus_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_bus_req", bus_req, 0);
    checkOutput("mrst_bus_we", bus_we, 0);
    checkOutput("mrst_stall", stall, 0);
    checkOutput("mrst_bus_addr", bus_addr, 32'h0);
    checkOutput("mrst_bus_wdata", bus_wdata, 32'h0);
    checkOutput("mrst_rdata", rdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("mrst_after_err", err, 0);
    checkOutput("mrst_after_rvalid", rvalid, 0);
    checkOutput("mrst_after_bus_req", bus_req, 0);
    checkOutput("mrst_after_stall", stall, 0);
    checkOutput("mrst_after_rdata", rdata, 32'h0);

    // Controller is back in IDLE and accepts a new load
    applyStimulus(1, 0, 32'h0000_0400, 32'h0, 0, 0, 32'h0);
    checkOutput("post_accept_stall", stall, 1);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 1, 32'h1357_9BDF);
    checkOutput("post_bus_addr", bus_addr, 32'h0000_0400);
    tick();
    applyStimulus(0, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    checkOutput("post_rdata", rdata, 32'h1357_9BDF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: number of REQ-state cycles without bus_ack before the access aborts (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port memrd  input  1  pipeline requests a word load this cycle.
REQ-005 SHALL have port memwr  input  1  pipeline requests a word store this cycle.
REQ-006 SHALL have port addr  input  32  byte address of the access.
REQ-007 SHALL have port wdata  input  32  store data.
REQ-008 SHALL have port flush  input  1  pipeline flush (interrupt or branch); suppresses acceptance of a new access.
REQ-009 SHALL have port stall  output  1  holds the pipeline while an access is pending.
REQ-010 SHALL have port rdata  output  32  last completed load data.
REQ-011 SHALL have port rvalid  output  1  one-cycle pulse: rdata updated by the current load.
REQ-012 SHALL have port err  output  1  one-cycle pulse: access aborted.
REQ-013 SHALL have ports bus_req  output  1, bus_we  output  1, bus_addr  output  32, bus_wdata  output  32: external memory request.
REQ-014 SHALL have ports bus_ack  input  1, bus_rdata  input  32: external memory response, valid in the cycle bus_ack=1.

Function
REQ-015 SHALL implement the FSM states IDLE, REQ, DONE and ERR.
REQ-016 IDLE, with (memrd|memwr)=1, flush=0, exactly one of memrd/memwr set, and addr[1:0]=0: SHALL latch addr, wdata and we=memwr; next state REQ.
REQ-017 IDLE with memrd=memwr=1, or with addr[1:0]!=0 (and flush=0): SHALL issue no bus request; next state ERR.
REQ-018 IDLE with flush=1: SHALL accept nothing; stays IDLE.
REQ-019 stall SHALL be combinational: 1 in IDLE when an access is requested and flush=0; 1 throughout REQ; 0 in DONE and ERR.
REQ-020 REQ: bus_req=1; bus_we, bus_addr and bus_wdata SHALL come from the latched values and stay stable until bus_ack.
REQ-021 Outside REQ: bus_req=0 and bus_we=0.
REQ-022 REQ with bus_ack=1: next state DONE; for a load, bus_rdata SHALL be captured into rdata.
REQ-023 REQ timeout counter, 8-bit: SHALL clear on entry to REQ and increment each REQ cycle without ack.
REQ-024 Timeout: when the counter reaches TIMEOUT-1 with bus_ack=0, next state SHALL be ERR; if bus_ack=1 in that same cycle, ack wins and next state is DONE.
REQ-025 DONE: rvalid SHALL be 1 for a load and 0 for a store; memrd/memwr SHALL be ignored; next state IDLE.
REQ-026 ERR: err=1; memrd/memwr ignored; next state IDLE.
REQ-027 flush asserted in REQ SHALL NOT abort the access; the transaction completes normally.
REQ-028 bus_ack received outside REQ SHALL be ignored.
REQ-029 rdata SHALL hold its value until the next completed load.
REQ-030 Best-case load latency: accept cycle (stall=1), one REQ cycle with ack, DONE cycle with rvalid=1; 2 stall cycles in total.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, stall=0, rvalid=0, err=0, rdata=0, counter=0.
REQ-032 Reset asserted during REQ SHALL drop bus_req asynchronously; the access is lost without an err pulse.

Verification
REQ-033 Load hit: memrd=1, addr=0x0000_1000; bus_ack=1 with bus_rdata=0xDEAD_BEEF in the first REQ cycle -> stall=1 for 2 cycles, then rvalid=1 and rdata=0xDEAD_BEEF in DONE.
REQ-034 Store with wait states: memwr=1, addr=0x0000_2FFC, wdata=0x1234_5678; ack after 3 REQ cycles -> bus signals stable for 3 cycles, bus_we=1, rvalid=0, err=0.
REQ-035 Timeout: TIMEOUT=4, memrd=1, no ack -> bus_req high for exactly 4 cycles, then err=1 for one cycle, stall=0, rdata unchanged.
REQ-036 Illegal request: memrd=memwr=1, or addr=0x0000_1002 -> bus_req never asserts; err pulses in the next cycle.
REQ-037 Flush and stray ack: flush=1 with memwr=1 in IDLE -> no request; bus_ack=1 while IDLE -> no state change.
REQ-038 Reset mid-access: rst_n=0 during REQ -> bus_req=0 immediately; after reset, all outputs are 0 and the state is IDLE.
